apb_mem_responder: RTL and testbench
====================================

# apb_mem_responder

APB responder (completer) backed by a parameterised word-addressed register file, with programmable wait states and error signalling. It connects directly to the APB master's bus outputs and returns PRDATA/PREADY/PSLVERR. It is the memory-mapped peripheral endpoint for the APB subsystem and the team's standard bus-compliant target for master bring-up.

## Interface
- DEPTH, 16, number of 32-bit words (power of two, 2..256)
- BASE_ADDR, 32'h0000_0000, byte address of word 0 (DEPTH*4-aligned)
- WAIT_CYCLES, 1, wait states inserted in every access phase (0..15)
- PCLK  in  1  clock; all logic on rising edge
- PRESET  in  1  reset, synchronous, active-low
- PSELx  in  1  responder select
- PENABLE  in  1  access-phase indicator
- PWRITE  in  1  1 = write, 0 = read
- PADDR  in  32  byte address
- PWDATA  in  32  write data
- PSTRB  in  4  byte write strobes (only with APB_RESP_PSTRB_EN)
- PRDATA  out  32  read data, valid when PREADY=1 on a read
- PREADY  out  1  transfer completes in this cycle
- PSLVERR  out  1  error response, valid only when PREADY=1

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- IDLE -> SETUP when PSELx=1, PENABLE=0. In SETUP, latch PADDR, PWRITE, PWDATA (and PSTRB), compute decode, load wait counter with WAIT_CYCLES.
- SETUP -> ACCESS unconditionally on next edge. If master presents PENABLE=0 in ACCESS, it is a protocol violation: return to IDLE with no write and no PREADY.
- ACCESS: counter decrements each cycle; PREADY=1 in the cycle the counter is 0. ACCESS -> SETUP if PSELx=1 and PENABLE=0 in the cycle after PREADY (back-to-back transfer), otherwise -> IDLE.
- Decode: offset = PADDR - BASE_ADDR; valid iff PADDR >= BASE_ADDR, offset/4 < DEPTH, PADDR[1:0] == 0. Index = offset[log2(DEPTH)+1:2].
- Valid write: word updated at the edge ending the PREADY cycle; PSLVERR=0.
- Valid read: PRDATA = mem[index] in PREADY cycle; PSLVERR=0.
- Invalid address: PREADY as normal, PSLVERR=1, PRDATA=0, no memory update.
- PSELx deasserted during ACCESS before PREADY: abort, return to IDLE, no write, PREADY stays 0.
- PRDATA held at 0 outside a read PREADY cycle.

## Timing
- Reset (PRESET=0 at a rising edge): PRDATA=0, PREADY=0, PSLVERR=0, FSM=IDLE, counter=0, every memory word=0. Applies mid-transfer; the in-flight transfer is dropped with no write.
- PREADY, PRDATA, PSLVERR are registered outputs.
- Latency: PREADY asserted in access cycle WAIT_CYCLES+1; minimum transfer = 2 cycles (WAIT_CYCLES=0), i.e. transfer length = 2 + WAIT_CYCLES.
- PREADY is high for exactly one cycle per transfer.
- A read of a word in the cycle after a write to it returns the new value.

## Configuration
- APB_RESP_PSTRB_EN defined: PSTRB port present; on a valid write only bytes with PSTRB[i]=1 are updated (byte i = bits 8i+7:8i); PSTRB=4'b0000 write completes with PSLVERR=0 and no change.
- Undefined: PSTRB port absent; every valid write updates all 4 bytes.

## Structure
- Shared package apb_pkg: FSM state enum (IDLE, SETUP, ACCESS), APB data/address width constants (32), strobe width constant (4).
- One sub-module apb_resp_mem: DEPTH x 32 storage with synchronous reset clear, byte-enable write port and read port; the FSM, decode and wait counter remain in apb_mem_responder.

## Test plan
- Reset then read addr 0x04 (WAIT_CYCLES=1) -> PREADY in 2nd access cycle, PRDATA=0, PSLVERR=0.
- Write 0xDEADBEEF to 0x08, then back-to-back read 0x08 -> PRDATA=0xDEADBEEF; each transfer exactly 3 cycles.
- Read 0x40 with DEPTH=16 and write to 0x06 (unaligned) -> PSLVERR=1 with PREADY, PRDATA=0, memory unchanged.
- Drop PSELx in the first access cycle of a write of 0x12345678 to 0x0C with WAIT_CYCLES=3 -> no PREADY; later read of 0x0C returns prior value.
- Assert PRESET=0 during access phase after writing 0xA5A5A5A5 to 0x00 -> outputs 0 next cycle; read 0x00 returns 0.
- With APB_RESP_PSTRB_EN: word 0x11223344 at 0x10, write 0xAABBCCDD with PSTRB=4'b0101 -> read returns 0x11BB33DD.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared APB definitions: responder FSM states and bus width constants.
package apb_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } apb_state_e;

endpackage

// File: rtl/apb_mem_responder_if.sv
// APB bus bundle between a master and the memory responder.
// PSTRB exists only when APB_RESP_PSTRB_EN is defined.
interface apb_mem_responder_if;
  import apb_pkg::*;

  logic              PSELx;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
`ifdef APB_RESP_PSTRB_EN
  logic [STRB_W-1:0] PSTRB;
`endif
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;

`ifdef APB_RESP_PSTRB_EN
  modport master (output PSELx, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
                  input  PRDATA, PREADY, PSLVERR);
  modport slave  (input  PSELx, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
                  output PRDATA, PREADY, PSLVERR);
`else
  modport master (output PSELx, PENABLE, PWRITE, PADDR, PWDATA,
                  input  PRDATA, PREADY, PSLVERR);
  modport slave  (input  PSELx, PENABLE, PWRITE, PADDR, PWDATA,
                  output PRDATA, PREADY, PSLVERR);
`endif

endinterface

// File: rtl/apb_resp_mem.sv
// DEPTH x 32 word storage: synchronous clear, byte-enable write, combinational read
// (the responder registers the read result into PRDATA).
module apb_resp_mem
  import apb_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [STRB_W-1:0] wstrb,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      for (int b = 0; b < int'(STRB_W); b++) begin
        if (wstrb[b]) begin
          mem_q[waddr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/apb_mem_responder.sv
// APB completer over a word register file with WAIT_CYCLES wait states and PSLVERR on bad
// addresses. Define APB_RESP_PSTRB_EN to honour per-byte write strobes.
module apb_mem_responder
  import apb_pkg::*;
#(
  parameter int unsigned       DEPTH       = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned       WAIT_CYCLES = 1
) (
  input logic                 PCLK,
  input logic                 PRESET,
  apb_mem_responder_if.slave  apb
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam logic [3:0]  WAIT_LD = 4'(WAIT_CYCLES);

  apb_state_e        state_q;
  logic [3:0]        cnt_q;
  logic [AW-1:0]     idx_q;
  logic              write_q;
  logic              valid_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] strb_q;
  logic              pready_q;
  logic [DATA_W-1:0] prdata_q;
  logic              pslverr_q;

  logic [ADDR_W-1:0] offset;
  logic              addr_ok;
  logic [AW-1:0]     cur_idx;
  logic [STRB_W-1:0] cur_strb;
  logic [AW-1:0]     rd_idx;
  logic [DATA_W-1:0] rd_data;
  logic              mem_we;

  // BASE_ADDR is DEPTH*4 aligned, so alignment and range can be judged on the offset.
  assign offset  = apb.PADDR - BASE_ADDR;
  assign addr_ok = (apb.PADDR >= BASE_ADDR) && (offset[ADDR_W-1:AW+2] == '0) &&
                   (offset[1:0] == 2'b00);
  assign cur_idx = offset[AW+1:2];

`ifdef APB_RESP_PSTRB_EN
  assign cur_strb = apb.PSTRB;
`else
  assign cur_strb = '1;
`endif

  // With zero wait states the read happens while the setup phase is still on the bus.
  assign rd_idx = (state_q == IDLE) ? cur_idx : idx_q;
  assign mem_we = (state_q != IDLE) && pready_q && apb.PSELx && apb.PENABLE &&
                  write_q && valid_q;

  apb_resp_mem #(.DEPTH(DEPTH)) u_mem (
    .clk   (PCLK),
    .rst_n (PRESET),
    .we    (mem_we),
    .waddr (idx_q),
    .wdata (wdata_q),
    .wstrb (strb_q),
    .raddr (rd_idx),
    .rdata (rd_data)
  );

  always_ff @(posedge PCLK) begin
    if (!PRESET) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      write_q   <= 1'b0;
      valid_q   <= 1'b0;
      wdata_q   <= '0;
      strb_q    <= '0;
      pready_q  <= 1'b0;
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
    end else begin
      pready_q  <= 1'b0;
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (apb.PSELx && !apb.PENABLE) begin
            idx_q   <= cur_idx;
            valid_q <= addr_ok;
            write_q <= apb.PWRITE;
            wdata_q <= apb.PWDATA;
            strb_q  <= cur_strb;
            cnt_q   <= WAIT_LD;
            state_q <= SETUP;
            if (WAIT_LD == 4'd0) begin
              pready_q  <= 1'b1;
              pslverr_q <= !addr_ok;
              prdata_q  <= (addr_ok && !apb.PWRITE) ? rd_data : '0;
            end
          end
        end
        SETUP, ACCESS: begin
          // Completion, deselect and a missing PENABLE all end the transfer here.
          if (!apb.PSELx || !apb.PENABLE || pready_q) begin
            state_q <= IDLE;
          end else begin
            cnt_q   <= cnt_q - 4'd1;
            state_q <= ACCESS;
            if (cnt_q == 4'd1) begin
              pready_q  <= 1'b1;
              pslverr_q <= !valid_q;
              prdata_q  <= (valid_q && !write_q) ? rd_data : '0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign apb.PREADY  = pready_q;
  assign apb.PRDATA  = prdata_q;
  assign apb.PSLVERR = pslverr_q;

endmodule

// File: tb/tb_apb_mem_responder.sv
// Self-checking bench for apb_mem_responder: directed vector table, corner-case sequences
// and random transfers against a word-array reference model (APB_RESP_PSTRB_EN optional).
module tb_apb_mem_responder;

  localparam int unsigned DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int unsigned WAITS = 1;

  logic pclk = 1'b0;
  logic preset = 1'b0;
  always #5 pclk = ~pclk;

  apb_mem_responder_if bus ();

  apb_mem_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(WAITS)) dut (
    .PCLK   (pclk),
    .PRESET (preset),
    .apb    (bus)
  );

  int errors = 0;
  int checks = 0;
  logic [3:0]  cur_strb = 4'hF;
  logic [31:0] model_mem [DEPTH];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit model_ok(input logic [31:0] a);
    longint off;
    off = longint'({32'd0, a}) - longint'({32'd0, BASE});
    return (off >= 0) && (off < longint'(DEPTH) * 4) && (a % 4 == 0);
  endfunction

  function automatic int model_idx(input logic [31:0] a);
    return int'((a - BASE) / 4);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < int'(DEPTH); i++) model_mem[i] = '0;
  endtask

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    if (model_ok(a)) begin
      for (int b = 0; b < 4; b++) begin
        if (s[b]) model_mem[model_idx(a)][8*b +: 8] = d[8*b +: 8];
      end
    end
  endtask

  task automatic bus_idle();
    bus.PSELx = 1'b0;
    bus.PENABLE = 1'b0;
  endtask

  // Called on a falling edge; returns on the falling edge of the cycle after PREADY.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      output logic [31:0] rdata, output logic slverr, output int len);
    int acc;
    bit done;
    bus.PSELx = 1'b1;
    bus.PENABLE = 1'b0;
    bus.PWRITE = wr;
    bus.PADDR = addr;
    bus.PWDATA = wdata;
`ifdef APB_RESP_PSTRB_EN
    bus.PSTRB = cur_strb;
`endif
    rdata = '0;
    slverr = 1'b0;
    acc = 0;
    done = 1'b0;
    @(negedge pclk);
    bus.PENABLE = 1'b1;
    while (!done && acc < 32) begin
      acc++;
      if (bus.PREADY === 1'b1) begin
        done = 1'b1;
        rdata = bus.PRDATA;
        slverr = bus.PSLVERR;
      end else begin
        @(negedge pclk);
      end
    end
    len = 1 + acc;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL pready_timeout: got no PREADY within %0d cycles for addr %h", acc, addr);
    end
    @(negedge pclk);
    bus_idle();
    chk("pready_single_cycle", {31'd0, bus.PREADY}, 32'd0);
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [11];

  initial begin
    logic [31:0] rd;
    logic err;
    int len;

    vecs[0]  = '{1'b0, 32'h04, 32'h0,         32'h0,         1'b0};
    vecs[1]  = '{1'b1, 32'h08, 32'hDEADBEEF,  32'h0,         1'b0};
    vecs[2]  = '{1'b0, 32'h08, 32'h0,         32'hDEADBEEF,  1'b0};
    vecs[3]  = '{1'b0, 32'h40, 32'h0,         32'h0,         1'b1};
    vecs[4]  = '{1'b1, 32'h06, 32'h55555555,  32'h0,         1'b1};
    vecs[5]  = '{1'b0, 32'h04, 32'h0,         32'h0,         1'b0};
    vecs[6]  = '{1'b0, 32'h08, 32'h0,         32'hDEADBEEF,  1'b0};
    vecs[7]  = '{1'b1, 32'h3C, 32'hCAFEF00D,  32'h0,         1'b0};
    vecs[8]  = '{1'b0, 32'h3C, 32'h0,         32'hCAFEF00D,  1'b0};
    vecs[9]  = '{1'b0, 32'h3E, 32'h0,         32'h0,         1'b1};
    vecs[10] = '{1'b1, 32'h0C, 32'h0BADC0DE,  32'h0,         1'b0};

    bus_idle();
    bus.PWRITE = 1'b0;
    bus.PADDR = '0;
    bus.PWDATA = '0;
`ifdef APB_RESP_PSTRB_EN
    bus.PSTRB = 4'hF;
`endif
    model_clear();
    repeat (3) @(negedge pclk);
    chk("reset_pready", {31'd0, bus.PREADY}, 32'd0);
    chk("reset_prdata", bus.PRDATA, 32'd0);
    chk("reset_pslverr", {31'd0, bus.PSLVERR}, 32'd0);
    preset = 1'b1;
    @(negedge pclk);

    // Directed table, issued back to back.
    for (int i = 0; i < 11; i++) begin
      xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, err, len);
      if (vecs[i].wr) model_write(vecs[i].addr, vecs[i].wdata, 4'hF);
      $display("vec %0d wr=%0d addr=%h rdata=%h err=%0d len=%0d", i, vecs[i].wr, vecs[i].addr,
               rd, err, len);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_slverr", i), {31'd0, err}, {31'd0, vecs[i].exp_err});
      chk($sformatf("vec%0d_len", i), len, 2 + WAITS);
    end

    // Deselect in the first access cycle: no PREADY, no write.
    bus.PSELx = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1;
    bus.PADDR = 32'h0C; bus.PWDATA = 32'h12345678;
    @(negedge pclk);
    bus_idle();
    chk("abort_pready0", {31'd0, bus.PREADY}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge pclk);
      chk("abort_pready", {31'd0, bus.PREADY}, 32'd0);
    end
    xfer(1'b0, 32'h0C, 32'h0, rd, err, len);
    $display("abort readback addr=0c rdata=%h", rd);
    chk("abort_readback", rd, 32'h0BADC0DE);

    // PENABLE missing in the access cycle: transfer dropped.
    bus.PSELx = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1;
    bus.PADDR = 32'h08; bus.PWDATA = 32'hFFFFFFFF;
    @(negedge pclk);
    chk("noen_pready0", {31'd0, bus.PREADY}, 32'd0);
    @(negedge pclk);
    bus_idle();
    chk("noen_pready1", {31'd0, bus.PREADY}, 32'd0);
    @(negedge pclk);
    xfer(1'b0, 32'h08, 32'h0, rd, err, len);
    $display("no-penable readback addr=08 rdata=%h", rd);
    chk("noen_readback", rd, 32'hDEADBEEF);

    // Reset during the access phase of an in-flight write.
    xfer(1'b1, 32'h00, 32'hA5A5A5A5, rd, err, len);
    bus.PSELx = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1;
    bus.PADDR = 32'h04; bus.PWDATA = 32'h5A5A5A5A;
    @(negedge pclk);
    bus.PENABLE = 1'b1;
    preset = 1'b0;
    @(negedge pclk);
    chk("midrst_pready", {31'd0, bus.PREADY}, 32'd0);
    chk("midrst_prdata", bus.PRDATA, 32'd0);
    chk("midrst_pslverr", {31'd0, bus.PSLVERR}, 32'd0);
    preset = 1'b1;
    bus_idle();
    model_clear();
    @(negedge pclk);
    xfer(1'b0, 32'h00, 32'h0, rd, err, len);
    $display("post-reset read addr=00 rdata=%h", rd);
    chk("midrst_read0", rd, 32'd0);
    xfer(1'b0, 32'h04, 32'h0, rd, err, len);
    $display("post-reset read addr=04 rdata=%h", rd);
    chk("midrst_read4", rd, 32'd0);

`ifdef APB_RESP_PSTRB_EN
    cur_strb = 4'hF;
    xfer(1'b1, 32'h10, 32'h11223344, rd, err, len);
    cur_strb = 4'b0101;
    xfer(1'b1, 32'h10, 32'hAABBCCDD, rd, err, len);
    chk("strb_err", {31'd0, err}, 32'd0);
    cur_strb = 4'b0000;
    xfer(1'b1, 32'h10, 32'hFFFFFFFF, rd, err, len);
    chk("strb0_err", {31'd0, err}, 32'd0);
    cur_strb = 4'hF;
    xfer(1'b0, 32'h10, 32'h0, rd, err, len);
    $display("strobe read addr=10 rdata=%h", rd);
    chk("strb_read", rd, 32'h11BB33DD);
    model_write(32'h10, 32'h11BB33DD, 4'hF);
`endif

    // Random traffic against the reference model.
    for (int n = 0; n < 150; n++) begin
      logic        wr;
      logic [31:0] a;
      logic [31:0] d;
      logic [31:0] exp_rd;
      wr = 1'($urandom_range(0, 1));
      a = 32'($urandom_range(0, 19) * 4);
      if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
      d = $urandom;
`ifdef APB_RESP_PSTRB_EN
      cur_strb = 4'($urandom_range(0, 15));
`else
      cur_strb = 4'hF;
`endif
      exp_rd = (!wr && model_ok(a)) ? model_mem[model_idx(a)] : 32'd0;
      xfer(wr, a, d, rd, err, len);
      if (wr) model_write(a, d, cur_strb);
      $display("rnd %0d wr=%0d addr=%h wdata=%h strb=%h rdata=%h err=%0d len=%0d", n, wr, a, d,
               cur_strb, rd, err, len);
      chk("rnd_rdata", rd, exp_rd);
      chk("rnd_slverr", {31'd0, err}, {31'd0, !model_ok(a)});
      chk("rnd_len", len, 2 + WAITS);
      repeat ($urandom_range(0, 2)) @(negedge pclk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
